// File: rtl/anita4_trig_pkg.sv
// Shared ANITA-4 L1 trigger definitions: channel layout, mask-servo FSM states and mask polarity.
package anita4_trig_pkg;

   localparam int NCHAN      = 12;
   localparam int PHI_STRIDE = 6;

   // Channel bit for phi sector p and position k is PHI_STRIDE*p + k.
   localparam int BOT_R = 0;
   localparam int BOT_L = 1;
   localparam int MID_R = 2;
   localparam int MID_L = 3;
   localparam int TOP_R = 4;
   localparam int TOP_L = 5;

   localparam logic MASK_DISABLED = 1'b1;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_COUNT,
      ST_EVAL
   } servo_state_e;

endpackage

// File: rtl/anita4_scaler_chan.sv
// One L1 scaler channel: saturating pulse counter, gate snapshot, and auto-mask bit with hold countdown.
module anita4_scaler_chan
   import anita4_trig_pkg::*;
#(
   parameter int CNT_WIDTH  = 16,
   parameter int HOLD_GATES = 8,
   parameter int HOLD_WIDTH = 4
) (
   input  logic                 clk_i,
   input  logic                 rst_n_i,
   input  logic                 run_i,
   input  logic                 pulse_i,
   input  logic                 snap_i,
   input  logic                 eval_i,
   input  logic                 clear_i,
   input  logic [CNT_WIDTH-1:0] rate_limit_i,
   output logic [CNT_WIDTH-1:0] snap_o,
   output logic                 auto_o,
   output logic                 auto_next_o
);

   logic [CNT_WIDTH-1:0]  cnt_q, cnt_d;
   logic [CNT_WIDTH-1:0]  snap_q, snap_d;
   logic [HOLD_WIDTH-1:0] hold_q, hold_d;
   logic                  auto_q, auto_d;

   // A pulse landing on the snapshot cycle belongs to the gate that starts there.
   always_comb begin
      cnt_d  = cnt_q;
      snap_d = snap_q;
      if (!run_i) begin
         cnt_d = '0;
      end else if (snap_i) begin
         snap_d = cnt_q;
         cnt_d  = {{(CNT_WIDTH-1){1'b0}}, pulse_i};
      end else if (pulse_i && (cnt_q != {CNT_WIDTH{1'b1}})) begin
         cnt_d = cnt_q + CNT_WIDTH'(1);
      end
   end

   always_comb begin
      auto_d = auto_q;
      hold_d = hold_q;
      if (clear_i) begin
         auto_d = 1'b0;
         hold_d = '0;
      end else if (snap_i && auto_q) begin
         hold_d = hold_q - HOLD_WIDTH'(1);
         if (hold_q <= HOLD_WIDTH'(1)) begin
            auto_d = 1'b0;
            hold_d = '0;
         end
      end else if (eval_i && !auto_q && (snap_q > rate_limit_i)) begin
         auto_d = 1'b1;
         hold_d = HOLD_WIDTH'(HOLD_GATES);
      end
   end

   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         cnt_q  <= '0;
         snap_q <= '0;
         hold_q <= '0;
         auto_q <= 1'b0;
      end else begin
         cnt_q  <= cnt_d;
         snap_q <= snap_d;
         hold_q <= hold_d;
         auto_q <= auto_d;
      end
   end

   assign snap_o      = snap_q;
   assign auto_o      = auto_q;
   assign auto_next_o = auto_d;

endmodule

// File: rtl/anita4_l1_mask_servo.sv
// Hot-channel mask servo: gates the L1 scaler counts, evaluates one channel per cycle after each
// gate and drives the combined user/auto channel mask to the L1 trigger.
module anita4_l1_mask_servo #(
   parameter int NCHAN      = anita4_trig_pkg::NCHAN,
   parameter int CNT_WIDTH  = 16,
   parameter int GATE_WIDTH = 24,
   parameter int HOLD_GATES = 8
) (
   input  logic                  clk_i,
   input  logic                  rst_n_i,
   input  logic [NCHAN-1:0]      l1_scaler_i,
   input  logic                  enable_i,
   input  logic                  clear_i,
   input  logic [GATE_WIDTH-1:0] gate_len_i,
   input  logic [CNT_WIDTH-1:0]  rate_limit_i,
   input  logic [NCHAN-1:0]      user_mask_i,
   output logic [NCHAN-1:0]      mask_o,
   output logic [NCHAN-1:0]      auto_mask_o,
   output logic                  gate_done_o,
   input  logic [3:0]            rd_sel_i,
   output logic [CNT_WIDTH-1:0]  rd_data_o
);
   import anita4_trig_pkg::*;

   localparam int IDX_W  = $clog2(NCHAN);
   localparam int HOLD_W = $clog2(HOLD_GATES + 1);
   localparam logic [GATE_WIDTH-1:0] MIN_GATE = GATE_WIDTH'(NCHAN + 2);

   servo_state_e          state_q, state_d;
   logic [GATE_WIDTH-1:0] timer_q, timer_d;
   logic [GATE_WIDTH-1:0] gate_len_q, gate_len_d;
   logic [IDX_W-1:0]      idx_q, idx_d;
   logic [NCHAN-1:0]      mask_q, mask_d;
   logic [GATE_WIDTH-1:0] gate_len_clamped;
   logic                  run, snap_now, eval_now;
   logic [NCHAN-1:0]      auto_w, auto_next_w;
   logic [CNT_WIDTH-1:0]  snap_w [NCHAN];

   // The gate must outlast the EVAL sweep so evaluation never overlaps the next snapshot.
   assign gate_len_clamped = (gate_len_i < MIN_GATE) ? MIN_GATE : gate_len_i;
   assign run              = enable_i && (state_q != ST_IDLE);

   always_comb begin
      state_d    = state_q;
      timer_d    = timer_q;
      gate_len_d = gate_len_q;
      idx_d      = idx_q;
      snap_now   = 1'b0;
      eval_now   = 1'b0;
      if (!enable_i) begin
         state_d    = ST_IDLE;
         timer_d    = '0;
         gate_len_d = gate_len_clamped;
         idx_d      = '0;
      end else begin
         case (state_q)
            ST_IDLE: begin
               state_d    = ST_COUNT;
               timer_d    = GATE_WIDTH'(1);
               gate_len_d = gate_len_clamped;
            end
            default: begin
               if (timer_q == gate_len_q) begin
                  snap_now   = 1'b1;
                  timer_d    = GATE_WIDTH'(1);
                  gate_len_d = gate_len_clamped;
                  state_d    = ST_EVAL;
                  idx_d      = '0;
               end else begin
                  timer_d = timer_q + GATE_WIDTH'(1);
                  if (state_q == ST_EVAL) begin
                     eval_now = 1'b1;
                     if (clear_i || (idx_q == IDX_W'(NCHAN - 1))) begin
                        state_d = ST_COUNT;
                        idx_d   = '0;
                     end else begin
                        idx_d = idx_q + IDX_W'(1);
                     end
                  end
               end
            end
         endcase
      end
   end

   // Built from the next-cycle auto bits so sets and releases reach the trigger one cycle sooner.
   assign mask_d = user_mask_i | auto_next_w;

   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         state_q    <= ST_IDLE;
         timer_q    <= '0;
         gate_len_q <= MIN_GATE;
         idx_q      <= '0;
         mask_q     <= {NCHAN{MASK_DISABLED}};
      end else begin
         state_q    <= state_d;
         timer_q    <= timer_d;
         gate_len_q <= gate_len_d;
         idx_q      <= idx_d;
         mask_q     <= mask_d;
      end
   end

   for (genvar ch = 0; ch < NCHAN; ch++) begin : g_chan
      anita4_scaler_chan #(
         .CNT_WIDTH  (CNT_WIDTH),
         .HOLD_GATES (HOLD_GATES),
         .HOLD_WIDTH (HOLD_W)
      ) u_chan (
         .clk_i        (clk_i),
         .rst_n_i      (rst_n_i),
         .run_i        (run),
         .pulse_i      (l1_scaler_i[ch]),
         .snap_i       (snap_now),
         .eval_i       (eval_now && (idx_q == IDX_W'(ch))),
         .clear_i      (clear_i),
         .rate_limit_i (rate_limit_i),
         .snap_o       (snap_w[ch]),
         .auto_o       (auto_w[ch]),
         .auto_next_o  (auto_next_w[ch])
      );
   end

   always_comb begin
      rd_data_o = '0;
      if (int'(rd_sel_i) < NCHAN) begin
         rd_data_o = snap_w[rd_sel_i];
      end
   end

   assign mask_o      = mask_q;
   assign auto_mask_o = auto_w;
   assign gate_done_o = snap_now;

endmodule
